// File: rtl/mult_div_unit_pkg.sv
// Shared md_defs definitions: op encodings, default latencies and FSM states.
// Define MULT_DIV_MADD_EN to enable the madd (op 7) accumulate operation.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_MADD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int unsigned DEF_MULT_CYCLES = 5;
   localparam int unsigned DEF_DIV_CYCLES  = 10;

`ifdef MULT_DIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   // Ops that occupy the unit for several cycles; madd only when compiled in.
   function automatic logic is_multi_cycle(input md_op_e o);
      case (o)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_multi_cycle = 1'b1;
         MD_MADD:                            is_multi_cycle = MADD_EN;
         default:                            is_multi_cycle = 1'b0;
      endcase
   endfunction

   function automatic logic is_div(input md_op_e o);
      is_div = (o == MD_DIV) || (o == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Pure combinational 64-bit HI:LO result from the latched operands and op.
// write_en drops for divide-by-zero so HI/LO are left untouched.
module mult_div_unit_arith
   import mult_div_unit_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] acc,
   output logic [63:0] result,
   output logic        write_en
);

   logic [63:0] prod_u;
   logic [63:0] prod_s;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] div_u;
   logic [31:0] div_s;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq;
   logic [31:0] sr;
   logic [31:0] q_s;
   logic [31:0] r_s;

   // Low 64 bits of the sign-extended product equal the signed product.
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

   // Signed divide through magnitudes: 0x80000000 / -1 wraps back to 0x80000000.
   assign mag_a = a[31] ? (32'd0 - a) : a;
   assign mag_b = b[31] ? (32'd0 - b) : b;
   assign div_u = (b == 32'd0) ? 32'd1 : b;
   assign div_s = (b == 32'd0) ? 32'd1 : mag_b;
   assign uq    = a / div_u;
   assign ur    = a % div_u;
   assign sq    = mag_a / div_s;
   assign sr    = mag_a % div_s;
   assign q_s   = (a[31] ^ b[31]) ? (32'd0 - sq) : sq;
   assign r_s   = a[31] ? (32'd0 - sr) : sr;

   always_comb begin
      result   = acc;
      write_en = 1'b0;
      case (op)
         MD_MULT: begin
            result   = prod_s;
            write_en = 1'b1;
         end
         MD_MULTU: begin
            result   = prod_u;
            write_en = 1'b1;
         end
         MD_DIV: begin
            result   = {r_s, q_s};
            write_en = (b != 32'd0);
         end
         MD_DIVU: begin
            result   = {ur, uq};
            write_en = (b != 32'd0);
         end
         MD_MADD: begin
            result   = acc + prod_s;
            write_en = 1'b1;
         end
         default: begin
            result   = acc;
            write_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency mult/div, single-cycle mthi/mtlo.
// madd (op 7) is available only when MULT_DIV_MADD_EN is defined.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state;
   md_state_e   state_next;
   md_op_e      op_in;
   md_op_e      op_q;
   logic [31:0] rs_q;
   logic [31:0] rt_q;
   logic [31:0] counter;
   logic        accept;
   logic        launch;
   logic        done;
   logic [63:0] result;
   logic        write_en;

   assign op_in  = md_op_e'(op);
   assign accept = start && !cancel && (state == ST_IDLE);
   assign launch = accept && is_multi_cycle(op_in);
   assign done   = (state == ST_BUSY) && (counter == 32'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (launch) state_next = ST_BUSY;
         ST_BUSY: if (done)   state_next = ST_IDLE;
         default:             state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_BUSY);
   end

   mult_div_unit_arith u_arith (
      .op       (op_q),
      .a        (rs_q),
      .b        (rt_q),
      .acc      ({hi, lo}),
      .result   (result),
      .write_en (write_en)
   );

   // Operands are latched at launch so live rs/rt never reach the arithmetic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= MD_NONE;
         rs_q    <= 32'd0;
         rt_q    <= 32'd0;
         counter <= 32'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         if (launch) begin
            op_q    <= op_in;
            rs_q    <= rs;
            rt_q    <= rt;
            counter <= is_div(op_in) ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
         end else if (state == ST_BUSY) begin
            counter <= counter - 32'd1;
         end

         if (done && write_en) begin
            hi <= result[63:32];
            lo <= result[31:0];
         end

         if (accept && (op_in == MD_MTHI)) hi <= rs;
         if (accept && (op_in == MD_MTLO)) lo <= rs;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO values.
// Build with MULT_DIV_MADD_EN defined to exercise the madd expectations.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        cancel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int errors;
   int n;

   mult_div_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .rs     (rs),
      .rt     (rt),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, then count busy cycles; with disturb, hammer the inputs while busy.
   task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, output int cnt);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      step();
      start = 1'b0;
      op    = 3'd0;
      cnt   = 0;
      while (busy && cnt < 64) begin
         rs = $urandom;
         rt = $urandom;
         if (disturb) begin
            start  = 1'b1;
            op     = MD_MULT;
            cancel = cnt[0];
         end
         cnt++;
         step();
      end
      start  = 1'b0;
      op     = 3'd0;
      cancel = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      start  = 1'b0;
      op     = 3'd0;
      rs     = 32'd0;
      rt     = 32'd0;
      cancel = 1'b0;
      step();
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      step();

      run_md(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, n);
      check("mult_busy_cycles", n, 32'd5);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFA);

      run_md(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, n);
      check("multu_busy_cycles", n, 32'd5);
      check("multu_hi", hi, 32'h00000002);
      check("multu_lo", lo, 32'hFFFFFFFA);

      run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n);
      check("div_busy_cycles", n, 32'd10);
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_lo", lo, 32'hFFFFFFFD);

      run_md(MD_DIVU, 32'd7, 32'd0, 1'b0, n);
      check("divu0_busy_cycles", n, 32'd10);
      check("divu0_hi", hi, 32'hFFFFFFFF);
      check("divu0_lo", lo, 32'hFFFFFFFD);

      start = 1'b1; op = MD_MTHI; rs = 32'h12345678;
      step();
      start = 1'b0; op = 3'd0;
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_lo", lo, 32'hFFFFFFFD);
      check("mthi_busy", {31'd0, busy}, 32'd0);

      start = 1'b1; op = MD_MTLO; rs = 32'hCAFEBABE;
      step();
      start = 1'b0; op = 3'd0;
      check("mtlo_lo", lo, 32'hCAFEBABE);
      check("mtlo_hi", hi, 32'h12345678);

      start = 1'b1; cancel = 1'b1; op = MD_MULT; rs = 32'd9; rt = 32'd9;
      step();
      start = 1'b0; cancel = 1'b0; op = 3'd0;
      check("cancel_busy", {31'd0, busy}, 32'd0);
      step();
      check("cancel_hi", hi, 32'h12345678);
      check("cancel_lo", lo, 32'hCAFEBABE);

      run_md(MD_DIV, 32'd100, 32'd7, 1'b1, n);
      check("disturb_busy_cycles", n, 32'd10);
      check("disturb_hi", hi, 32'd2);
      check("disturb_lo", lo, 32'd14);
      step();
      check("disturb_no_restart", {31'd0, busy}, 32'd0);

      run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
      check("div_ovf_hi", hi, 32'h0);
      check("div_ovf_lo", lo, 32'h80000000);

      run_md(MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, n);
      check("div_negdiv_hi", hi, 32'd1);
      check("div_negdiv_lo", lo, 32'hFFFFFFFD);

      run_md(MD_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0, n);
      check("divu_hi", hi, 32'd1);
      check("divu_lo", lo, 32'h7FFFFFFC);

      start = 1'b1; op = MD_MTHI; rs = 32'd0;
      step();
      op = MD_MTLO; rs = 32'd10;
      step();
      start = 1'b0; op = 3'd0;
      run_md(MD_MADD, 32'd3, 32'd4, 1'b0, n);
`ifdef MULT_DIV_MADD_EN
      check("madd_busy_cycles", n, 32'd5);
      check("madd_hi", hi, 32'd0);
      check("madd_lo", lo, 32'd22);
      run_md(MD_MADD, 32'hFFFFFFFF, 32'd30, 1'b0, n);
      check("madd_neg_hi", hi, 32'hFFFFFFFF);
      check("madd_neg_lo", lo, 32'hFFFFFFF8);
`else
      check("madd_off_busy_cycles", n, 32'd0);
      check("madd_off_hi", hi, 32'd0);
      check("madd_off_lo", lo, 32'd10);
`endif

      start = 1'b1; op = MD_DIV; rs = 32'd100; rt = 32'd7;
      step();
      start = 1'b0; op = 3'd0;
      for (int i = 0; i < 6; i++) step();
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("midop_reset_hi", hi, 32'h0);
      check("midop_reset_lo", lo, 32'h0);
      check("midop_reset_busy", {31'd0, busy}, 32'd0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("post_reset_hi", hi, 32'h0);
      check("post_reset_lo", lo, 32'h0);
      check("post_reset_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage multiply/divide unit of the P7 MIPS pipeline.
- Consumes the ID/EX register outputs (RS_E, RT_E, IR_E decode) and owns the architectural HI/LO registers.
- Runs mult/multu/div/divu as fixed-latency multi-cycle operations and reports busy so the hazard unit can stall mfhi/mflo/md instructions in D.
- Performs mthi/mtlo in one cycle.

Parameters:
- MULT_CYCLES, 5, cycles from acceptance to HI/LO update for mult/multu (and madd when enabled); legal range >= 1.
- DIV_CYCLES, 10, cycles from acceptance to HI/LO update for div/divu; legal range >= 1.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX instruction is an md op this cycle (decoded from IR_E).
- op  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd.
- rs  in  32  first operand (RS_E, forwarded).
- rt  in  32  second operand (RT_E, forwarded).
- cancel  in  1  exception/interrupt taken at M this cycle; suppresses acceptance.
- busy  out  1  multi-cycle operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: reset low, asynchronously, forces hi=0, lo=0, busy=0, counter=0 and the operand latches to 0. Reset mid-operation abandons the operation; no HI/LO write afterwards.
- Acceptance: at a posedge with start=1, cancel=0, busy=0.
  - start while busy=1 is ignored. The hazard unit stalls D on (start|busy) and the instruction's op is md, so this never occurs legally.
  - op=0 with start=1 does nothing.
- mult/multu/div/divu: on acceptance, latch rs, rt and op, load counter with MULT_CYCLES or DIV_CYCLES, and set busy=1 at that edge.
  - Counter decrements each edge.
  - At the edge where counter==1: write HI/LO, clear busy.
  - busy is therefore high for exactly N cycles. New results are visible in the cycle after busy falls.
- mthi/mtlo: on acceptance, hi<=rs or lo<=rs at that edge. busy stays 0; the other register is unchanged.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs).
  - divu: unsigned quotient and remainder.
  - Divide by zero: HI and LO are left unchanged at completion; busy timing is identical.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are taken only from the latches, never from live rs/rt during busy.
- cancel:
  - cancel=1 with start=1 means no acceptance and no state change.
  - cancel while busy has no effect; the in-flight operation belongs to an older, committed instruction and completes normally.
- Simultaneous events: at the completion edge busy=0 only after that edge, so a start in the same cycle is ignored.
- Outputs hi, lo and busy are registers with no combinational path from inputs.

Optional Feature:
- Macro MULT_DIV_MADD_EN.
- Defined: op=7 (madd) behaves like mult with MULT_CYCLES latency, but at completion {hi,lo} <= {hi,lo} + signed(rs*rt), using the HI/LO value present at the completion edge.
- Not defined: op=7 is treated as op=0 (no acceptance, busy stays 0, HI/LO untouched).

Decomposition:
- Shared package / header `md_defs`:
  - op encoding constants MD_NONE..MD_MADD.
  - Default cycle counts.
- The ID/EX decode of IR_E into start/op uses the same constants.
- No sub-module required. Optionally factor `md_arith` (pure combinational 64-bit result computation from latched operands and op) to keep sequencing and arithmetic separate.

Test Plan:
- Reset low mid-div (counter=4) → hi=lo=0 and busy=0 immediately; no write after reset is released.
- mult rs=0xFFFFFFFE, rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 → hi/lo keep their prior values and busy lasts 10 cycles.
- mthi rs=0x12345678 → hi updates next edge, busy stays 0, lo unchanged. start+cancel with mult → no busy, no change.
- start mult while busy from a prior div → ignored; only the div result appears at cycle 10. Operands changed during busy do not affect the result.
- With MULT_DIV_MADD_EN, hi:lo=0:10, madd 3*4 → 0:22 after 5 cycles. Without the macro → busy never rises, 0:10 retained.
